// File: rtl/fcp6_pkg.sv
// Shared FCP6 bus definitions: lane encodings, opcodes, header layout and responder states.
// Used by the responder today and intended for the master as well.
package fcp6_pkg;

   typedef enum logic [1:0] {
      CTRL_IDLE = 2'b00,
      CTRL_HDR  = 2'b01,
      CTRL_PAY  = 2'b10,
      CTRL_END  = 2'b11
   } ctrl_e;

   localparam logic [1:0] OP_WR = 2'b11;
   localparam logic [1:0] OP_RD = 2'b10;

   // Field order fixes the header bit positions: [7:4] addr, [3:2] idx, [1:0] op.
   typedef struct packed {
      logic [3:0] addr;
      logic [1:0] idx;
      logic [1:0] op;
   } hdr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_WPAY,
      ST_RPAY,
      ST_END,
      ST_IGNORE
   } state_e;

endpackage

// File: rtl/fcp6_shift2.sv
// Loadable 8-bit shift register moving two bits per beat, with a beat counter.
// Shifts left so the MSB pair leaves first on transmit and arrives first on receive.
module fcp6_shift2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_shift,
   input  logic [1:0] i_din,
   output logic [7:0] o_q,
   output logic       o_last
);

   logic [7:0] r_q;
   logic [1:0] r_cnt;

   // NOTE: clocked state uses non-blocking assignments so every register samples
   // pre-edge values, independent of the order in which processes evaluate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_q   <= i_load_val;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_q   <= {r_q[5:0], i_din};
         r_cnt <= r_cnt + 2'd1;
      end
   end

   assign o_q    = r_q;
   assign o_last = i_shift && (r_cnt == 2'd3);

endmodule

// File: rtl/fcp6_slave.sv
// FCP6 responder: decodes header beats, commits writes to a 4x8 register file,
// serialises reads back to the master and acknowledges at frame end.
module fcp6_slave
   import fcp6_pkg::*;
#(
   parameter logic [3:0] DEV_ADDR = 4'b0110,
   parameter logic [7:0] RST_VAL  = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  bus_data_i,
   input  logic [1:0]  bus_ctrl_i,
   output logic [1:0]  bus_data_o,
   output logic        bus_data_oe,
   output logic        ack,
   output logic        busy,
   output logic        err,
   output logic        wr_strobe,
   output logic [31:0] reg_q
);

   ctrl_e      w_ctrl;
   state_e     r_state, w_state_nxt;
   hdr_t       w_hdr;
   logic [5:0] r_hdr_sr;
   logic [1:0] r_hdr_cnt;
   logic       w_hdr_shift, w_hdr_last;
   logic [7:0] w_dat_q;
   logic       w_dat_load, w_dat_shift, w_dat_last;
   logic [1:0] w_dat_din;
   logic [1:0] r_idx;
   logic       r_is_wr, r_rsv;
   logic       w_abort, w_commit, w_ign_end;
   logic       w_ack_nxt, w_err_nxt, w_wr_nxt, w_busy_nxt, w_oe_nxt;
   logic       r_ack, r_err, r_wr, r_busy, r_oe;
   logic [7:0] r_regs [4];

   assign w_ctrl = ctrl_e'(bus_ctrl_i);

   // Header is judged on its 4th beat, so the live pair completes the byte.
   assign w_hdr       = hdr_t'({r_hdr_sr, bus_data_i});
   assign w_hdr_shift = ((r_state == ST_IDLE) || (r_state == ST_HDR)) && (w_ctrl == CTRL_HDR);
   assign w_hdr_last  = (r_state == ST_HDR) && w_hdr_shift && (r_hdr_cnt == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hdr_sr  <= '0;
         r_hdr_cnt <= '0;
      end else if (w_hdr_shift) begin
         r_hdr_sr  <= {r_hdr_sr[3:0], bus_data_i};
         r_hdr_cnt <= r_hdr_cnt + 2'd1;
      end else begin
         r_hdr_cnt <= '0;
      end
   end

   assign w_dat_load  = w_hdr_last;
   assign w_dat_shift = ((r_state == ST_WPAY) || (r_state == ST_RPAY)) && (w_ctrl == CTRL_PAY);
   assign w_dat_din   = (r_state == ST_WPAY) ? bus_data_i : 2'b00;

   fcp6_shift2 u_dat (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_dat_load),
      .i_load_val ((w_hdr.op == OP_RD) ? r_regs[w_hdr.idx] : 8'h00),
      .i_shift    (w_dat_shift),
      .i_din      (w_dat_din),
      .o_q        (w_dat_q),
      .o_last     (w_dat_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_ctrl == CTRL_HDR) w_state_nxt = ST_HDR;
         ST_HDR: begin
            if (w_ctrl != CTRL_HDR)             w_state_nxt = ST_IDLE;
            else if (w_hdr_last) begin
               if (w_hdr.addr != DEV_ADDR)      w_state_nxt = ST_IGNORE;
               else if (w_hdr.op == OP_WR)      w_state_nxt = ST_WPAY;
               else if (w_hdr.op == OP_RD)      w_state_nxt = ST_RPAY;
               else                             w_state_nxt = ST_IGNORE;
            end
         end
         ST_WPAY, ST_RPAY: begin
            if (w_ctrl != CTRL_PAY)             w_state_nxt = ST_IDLE;
            else if (w_dat_last)                w_state_nxt = ST_END;
         end
         ST_END:                                w_state_nxt = ST_IDLE;
         ST_IGNORE: if ((w_ctrl == CTRL_END) || (w_ctrl == CTRL_IDLE)) w_state_nxt = ST_IDLE;
         default:                               w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_abort   = ((r_state == ST_HDR) && (w_ctrl != CTRL_HDR))
               || (((r_state == ST_WPAY) || (r_state == ST_RPAY)) && (w_ctrl != CTRL_PAY))
               || ((r_state == ST_END) && (w_ctrl != CTRL_END));
      w_commit  = (r_state == ST_END) && (w_ctrl == CTRL_END);
      w_ign_end = (r_state == ST_IGNORE) && ((w_ctrl == CTRL_END) || (w_ctrl == CTRL_IDLE));
      w_ack_nxt  = w_commit;
      w_wr_nxt   = w_commit && r_is_wr;
      w_err_nxt  = w_abort || (w_ign_end && r_rsv);
      w_busy_nxt = (w_state_nxt != ST_IDLE) || w_commit;
      w_oe_nxt   = (w_state_nxt == ST_RPAY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_wr    <= 1'b0;
         r_busy  <= 1'b0;
         r_oe    <= 1'b0;
         r_idx   <= '0;
         r_is_wr <= 1'b0;
         r_rsv   <= 1'b0;
      end else begin
         r_ack  <= w_ack_nxt;
         r_err  <= w_err_nxt;
         r_wr   <= w_wr_nxt;
         r_busy <= w_busy_nxt;
         r_oe   <= w_oe_nxt;
         if (w_hdr_last) begin
            r_idx   <= w_hdr.idx;
            r_is_wr <= (w_hdr.op == OP_WR);
            r_rsv   <= (w_hdr.addr == DEV_ADDR) && !w_hdr.op[1];
         end
      end
   end

   // NOTE: the register file is reset because its contents are architecturally
   // visible on reg_q; large RAM-style storage would normally be left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_regs[i] <= RST_VAL;
      end else if (w_wr_nxt) begin
         r_regs[r_idx] <= w_dat_q;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_regq
      assign reg_q[8*g +: 8] = r_regs[g];
   end

   assign bus_data_o  = r_oe ? w_dat_q[7:6] : 2'b00;
   assign bus_data_oe = r_oe;
   assign ack         = r_ack;
   assign busy        = r_busy;
   assign err         = r_err;
   assign wr_strobe   = r_wr;

endmodule

// File: tb/tb_fcp6_slave.sv
// Directed bench for fcp6_slave: a per-beat vector table for write/read frames,
// then hand-written sequences for mismatch, abort, reserved opcode and reset.
module tb_fcp6_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  bus_data_i, bus_ctrl_i, bus_data_o;
   logic        bus_data_oe, ack, busy, err, wr_strobe;
   logic [31:0] reg_q;
   int          n_pass = 0;
   int          n_total = 0;

   typedef struct {
      logic [1:0]  ctrl;
      logic [1:0]  data;
      logic        ack;
      logic        busy;
      logic        err;
      logic        wr;
      logic        oe;
      logic [1:0]  dout;
      logic [31:0] regs;
   } vec_t;

   vec_t vecs [19];

   fcp6_slave #(.DEV_ADDR(4'b0110), .RST_VAL(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_data_i  (bus_data_i),
      .bus_ctrl_i  (bus_ctrl_i),
      .bus_data_o  (bus_data_o),
      .bus_data_oe (bus_data_oe),
      .ack         (ack),
      .busy        (busy),
      .err         (err),
      .wr_strobe   (wr_strobe),
      .reg_q       (reg_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one beat, let the DUT sample it, then settle just after the edge.
   task automatic step(input logic [1:0] c, input logic [1:0] d);
      bus_ctrl_i = c;
      bus_data_i = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [1:0] c, input logic [7:0] b);
      for (int i = 3; i >= 0; i--) step(c, b[2*i+1 -: 2]);
   endtask

   task automatic step_quiet(input string name, input logic [1:0] c, input logic [1:0] d);
      step(c, d);
      check({name, " ack"}, 32'(ack), 32'd0);
      check({name, " oe"},  32'(bus_data_oe), 32'd0);
      check({name, " err"}, 32'(err), 32'd0);
   endtask

   initial begin
      // Write 0x67 / A5 (reg1), then back-to-back read 0x66 starting in the ack cycle.
      vecs[0]  = '{2'b01, 2'b01, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[1]  = '{2'b01, 2'b10, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[2]  = '{2'b01, 2'b01, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[3]  = '{2'b01, 2'b11, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[4]  = '{2'b10, 2'b10, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[5]  = '{2'b10, 2'b10, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[6]  = '{2'b10, 2'b01, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[7]  = '{2'b10, 2'b01, 0, 1, 0, 0, 0, 2'b00, 32'h0000_0000};
      vecs[8]  = '{2'b11, 2'b00, 1, 1, 0, 1, 0, 2'b00, 32'h0000_A500};
      vecs[9]  = '{2'b01, 2'b01, 0, 1, 0, 0, 0, 2'b00, 32'h0000_A500};
      vecs[10] = '{2'b01, 2'b10, 0, 1, 0, 0, 0, 2'b00, 32'h0000_A500};
      vecs[11] = '{2'b01, 2'b01, 0, 1, 0, 0, 0, 2'b00, 32'h0000_A500};
      vecs[12] = '{2'b01, 2'b10, 0, 1, 0, 0, 1, 2'b10, 32'h0000_A500};
      vecs[13] = '{2'b10, 2'b00, 0, 1, 0, 0, 1, 2'b10, 32'h0000_A500};
      vecs[14] = '{2'b10, 2'b00, 0, 1, 0, 0, 1, 2'b01, 32'h0000_A500};
      vecs[15] = '{2'b10, 2'b00, 0, 1, 0, 0, 1, 2'b01, 32'h0000_A500};
      vecs[16] = '{2'b10, 2'b00, 0, 1, 0, 0, 0, 2'b00, 32'h0000_A500};
      vecs[17] = '{2'b11, 2'b00, 1, 1, 0, 0, 0, 2'b00, 32'h0000_A500};
      vecs[18] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 32'h0000_A500};

      rst_n      = 1'b0;
      bus_ctrl_i = 2'b00;
      bus_data_i = 2'b00;
      #12;
      check("rst ack",  32'(ack), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst err",  32'(err), 32'd0);
      check("rst wr",   32'(wr_strobe), 32'd0);
      check("rst oe",   32'(bus_data_oe), 32'd0);
      check("rst dout", 32'(bus_data_o), 32'd0);
      check("rst regs", reg_q, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 19; v++) begin
         step(vecs[v].ctrl, vecs[v].data);
         check($sformatf("vec%0d ack", v),  32'(ack), 32'(vecs[v].ack));
         check($sformatf("vec%0d busy", v), 32'(busy), 32'(vecs[v].busy));
         check($sformatf("vec%0d err", v),  32'(err), 32'(vecs[v].err));
         check($sformatf("vec%0d wr", v),   32'(wr_strobe), 32'(vecs[v].wr));
         check($sformatf("vec%0d oe", v),   32'(bus_data_oe), 32'(vecs[v].oe));
         check($sformatf("vec%0d dout", v), 32'(bus_data_o), 32'(vecs[v].dout));
         check($sformatf("vec%0d regs", v), reg_q, vecs[v].regs);
      end

      // Address mismatch: header 0x17 write A5 is ignored silently.
      for (int i = 3; i >= 0; i--) step_quiet("mis hdr", 2'b01, 2'(8'h17 >> (2*i)));
      for (int i = 3; i >= 0; i--) step_quiet("mis pay", 2'b10, 2'(8'hA5 >> (2*i)));
      step_quiet("mis end", 2'b11, 2'b00);
      check("mis busy", 32'(busy), 32'd0);
      check("mis wr", 32'(wr_strobe), 32'd0);
      step(2'b00, 2'b00);
      check("mis regs", reg_q, 32'h0000_A500);

      // A following valid frame: write 0x3C to reg2.
      send_byte(2'b01, 8'h6B);
      send_byte(2'b10, 8'h3C);
      step(2'b11, 2'b00);
      check("wr2 ack", 32'(ack), 32'd1);
      check("wr2 wr", 32'(wr_strobe), 32'd1);
      check("wr2 regs", reg_q, 32'h003C_A500);
      step(2'b00, 2'b00);
      check("wr2 ack drop", 32'(ack), 32'd0);

      // Abort after two payload beats: err next cycle, reg1 untouched.
      send_byte(2'b01, 8'h67);
      step(2'b10, 2'b11);
      step(2'b10, 2'b11);
      step(2'b00, 2'b00);
      check("abt err", 32'(err), 32'd1);
      check("abt busy", 32'(busy), 32'd0);
      check("abt ack", 32'(ack), 32'd0);
      step(2'b00, 2'b00);
      check("abt err drop", 32'(err), 32'd0);
      check("abt regs", reg_q, 32'h003C_A500);

      // Reserved opcode with matching address: err at frame end only.
      send_byte(2'b01, 8'h64);
      check("rsv err early", 32'(err), 32'd0);
      step(2'b11, 2'b00);
      check("rsv err", 32'(err), 32'd1);
      check("rsv ack", 32'(ack), 32'd0);
      check("rsv wr", 32'(wr_strobe), 32'd0);
      step(2'b00, 2'b00);
      check("rsv err drop", 32'(err), 32'd0);

      // Reset asserted during read payload beat 2.
      send_byte(2'b01, 8'h66);
      step(2'b10, 2'b00);
      check("rrst oe before", 32'(bus_data_oe), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rrst oe", 32'(bus_data_oe), 32'd0);
      check("rrst busy", 32'(busy), 32'd0);
      check("rrst dout", 32'(bus_data_o), 32'd0);
      check("rrst regs", reg_q, 32'h0);
      @(negedge clk);
      bus_ctrl_i = 2'b00;
      rst_n      = 1'b1;
      @(posedge clk);
      #1;
      send_byte(2'b01, 8'h67);
      send_byte(2'b10, 8'h5A);
      step(2'b11, 2'b00);
      check("post ack", 32'(ack), 32'd1);
      check("post regs", reg_q, 32'h0000_5A00);
      step(2'b00, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fcp6_slave.md
Name: fcp6_slave

Overview:
Responder end of the FCP6 two-wire-pair bus driven by the existing master.
- Deserialises header and payload beats from the 2-bit data and 2-bit ctrl lanes.
- Decodes address, register index and opcode from the header.
- Commits writes to a small internal register file, or serialises register contents back to the master on reads.
- Returns a single-cycle ack at frame end.
- Sits on the bus opposite the master inside top-level integrations; multiple instances are distinguished by DEV_ADDR.

Parameters:
DEV_ADDR, 4'b0110, device address matched against header[7:4]
RST_VAL, 8'h00, reset value of every internal register

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
bus_data_i  input  2  data lane from master, 2 bits per beat, MSB pair first
bus_ctrl_i  input  2  beat type: 00 idle, 01 header, 10 payload, 11 end-of-frame
bus_data_o  output  2  data lane driven by slave during read payload
bus_data_oe  output  1  high while slave owns data lane
ack  output  1  one-cycle pulse: frame accepted and executed
busy  output  1  high from first header beat until frame completes or aborts
err  output  1  one-cycle pulse on protocol error for this device
wr_strobe  output  1  one-cycle pulse when a write is committed
reg_q  output  32  register file flattened, reg[i] = reg_q[8*i+7:8*i]

Behaviour:
- Reset (async, rst_n=0): state IDLE, counters 0, registers = RST_VAL; bus_data_o=00, bus_data_oe=0, ack=0, busy=0, err=0, wr_strobe=0.
- Header format: [7:4] address, [3:2] register index, [1:0] opcode (11 write, 10 read, 0x reserved).
- Beats are sampled on every rising edge; one beat per cycle, no stalls.
- IDLE: ctrl=01 captures header beat 0 (into hdr[7:6]), sets busy, goes to HDR with beat count 1. Any other ctrl value is ignored.
- HDR: each ctrl=01 beat shifts in the next pair. On the 4th beat, decide:
  - address mismatch -> IGNORE;
  - opcode 11 -> WPAY;
  - opcode 10 -> RPAY, shift register loaded with reg[idx], bus_data_oe=1 from the next cycle;
  - reserved opcode -> IGNORE, with err flagged at end of frame.
  - Any ctrl other than 01 before 4 beats -> abort.
- WPAY: collect exactly 4 beats with ctrl=10 into a staging byte, then go to END. A 5th ctrl=10 beat, or ctrl=01/11 early, aborts.
- RPAY: drive bus_data_o = shift[7:6] for 4 cycles, shifting left 2 each cycle. Sequence for A5 is 10,10,01,01. Master must hold ctrl=10 during these cycles; any other value aborts. bus_data_oe drops the cycle after the 4th beat.
- END: expects ctrl=11 next cycle.
  - Write: reg[idx] <= staging and wr_strobe=1, both in the cycle after ctrl=11 is sampled.
  - ack=1 in that same cycle; busy falls with it.
  - Write commit happens only here, so aborted frames have no side effect.
- IGNORE: stay silent (oe=0, no ack) until ctrl=11 or ctrl=00, then IDLE. err pulses only for a reserved opcode with matching address.
- Abort: ctrl=00 mid-frame or an illegal ctrl sequence.
  - err pulses next cycle; state -> IDLE; busy, oe and ack all 0.
  - Staging byte is discarded and registers are unchanged.
  - If an abort-causing beat is ctrl=01, it is NOT reinterpreted as a new header; the master must idle at least one cycle.
- Back-to-back: ctrl=01 in the ack cycle starts a new frame; header beat 0 is captured that cycle.
- Mid-operation reset: immediate return to reset values, including bus_data_oe=0 asynchronously.
- Total write latency: 4 hdr + 4 payload + 1 end + 1 ack = ack in the 10th cycle after the first header beat.

Decomposition:
- Package fcp6_pkg: ctrl encodings (CTRL_IDLE/HDR/PAY/END), opcode constants (OP_WR, OP_RD), header field positions, state enum.
- Shared with the master; reuse it there when it is next refactored.
- One natural sub-module: fcp6_shift2, a loadable 8-bit two-bit-per-beat shift register with beat counter, used for both rx deserialisation and tx serialisation.

Test Plan:
- Write: hdr 0x67, payload 0xA5, end -> reg_q[15:8]=A5, wr_strobe and ack high in the same single cycle, 10 cycles after first beat; busy high for 9 cycles.
- Read: after write, hdr 0x66 then 4 ctrl=10 beats -> bus_data_oe high 4 cycles, bus_data_o = 10,10,01,01; ack after end; reg_q unchanged.
- Address mismatch: hdr 0x17 write A5 -> no ack, no oe, no err, reg_q unchanged; a following valid frame to 0x6x is accepted.
- Abort: hdr 0x67, two payload beats, then ctrl=00 -> err pulse next cycle, state IDLE, reg1 keeps its old value, no ack.
- Reserved opcode: hdr 0x64 then end -> err pulse, no ack, no wr_strobe.
- Reset mid-read: rst_n low during RPAY beat 2 -> bus_data_oe=0 and busy=0 immediately; after release, registers = RST_VAL and the next write succeeds.
